// File: rtl/regfile_pkg.sv
// Shared types, defaults and slicing helper for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 1;

  // Helper operates on fixed-size containers; callers zero-extend the packed
  // bus into MAX_BUS_W and narrow the result back with a size cast.
  localparam int MAX_FIELD_W = 128;
  localparam int MAX_BUS_W   = 512;

  // Extract field idx (width w) from a packed bus of equally sized fields.
  function automatic logic [MAX_FIELD_W-1:0] unpack_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   idx,
    input int                   w
  );
    logic [MAX_BUS_W-1:0]   sh;
    logic [MAX_FIELD_W-1:0] mask;
    sh   = bus >> (idx * w);
    mask = (w >= MAX_FIELD_W) ? '1 : ((MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1));
    return sh[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks every entry once, one per cycle, and holds
// busy_o while doing so.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // State and pointer registers; next values already fold in reset.
  always_ff @(posedge clk_i) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
  end

  // Next-state and outputs; reset restarts the walk from entry 0 in any state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_o  = 1'b0;
    clr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        busy_o = 1'b1;
        clr_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end
  end

  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero entry, optional
// write-to-read bypass and a cycle-per-entry clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o
);

  logic [NUM_WR-1:0][ADDR_W-1:0] wa;
  logic [NUM_WR-1:0][DATA_W-1:0] wd;
  logic [NUM_WR-1:0]             wr_ok;
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rd;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clr_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .busy_o   (busy_o),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Unpack write ports; writes to entry 0 vanish when it is hard-wired.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k]    = ADDR_W'(unpack_slice(MAX_BUS_W'(wr_addr_i), k, ADDR_W));
    assign wd[k]    = DATA_W'(unpack_slice(MAX_BUS_W'(wr_data_i), k, DATA_W));
    assign wr_ok[k] = wr_en_i[k] && !((ZERO_REG != 0) && (wa[k] == '0));
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_ra
    assign ra[j] = ADDR_W'(unpack_slice(MAX_BUS_W'(rd_addr_i), j, ADDR_W));
  end

  // Storage update: the clear engine owns the array while running; otherwise
  // ports apply in ascending order so the highest-numbered port wins a tie.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (!rst_i && !busy_o) begin
      for (int k = 0; k < NUM_WR; k++)
        if (wr_ok[k]) mem[wa[k]] <= wd[k];
    end
  end

  // Read muxes: array value, then optional bypass, then forced-zero cases.
  always_comb begin
    rd = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd[j] = mem[ra[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++)
          if (wr_ok[k] && (wa[k] == ra[j])) rd[j] = wd[k];
      end
      if (busy_o || ((ZERO_REG != 0) && (ra[j] == '0))) rd[j] = '0;
    end
  end

  assign rd_data_o = rd;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: two instances, A (2W, zero entry, bypass) and
// B (1W, ordinary entry 0, no bypass), driven from shared clock/reset/clear.
module tb_regfile_mp;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i, clear_i;
  logic busy_a, busy_b;

  logic [1:0]       wen_a;
  logic [1:0][4:0]  waddr_a;
  logic [1:0][31:0] wdata_a;
  logic [1:0][4:0]  raddr_a;
  logic [1:0][31:0] rdata_a;

  logic [0:0]       wen_b;
  logic [4:0]       waddr_b;
  logic [31:0]      wdata_b;
  logic [1:0][4:0]  raddr_b;
  logic [1:0][31:0] rdata_b;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_mp #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .busy_o    (busy_a),
    .wr_en_i   (wen_a),
    .wr_addr_i (waddr_a),
    .wr_data_i (wdata_a),
    .rd_addr_i (raddr_a),
    .rd_data_o (rdata_a)
  );

  regfile_mp #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .busy_o    (busy_b),
    .wr_en_i   (wen_b),
    .wr_addr_i (waddr_b),
    .wr_data_i (wdata_b),
    .rd_addr_i (raddr_b),
    .rd_data_o (rdata_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr_a[0] = 5'(i);
      raddr_a[1] = 5'(31 - i);
      raddr_b    = raddr_a;
      #1;
      chk(tag, rdata_a, 64'd0);
      chk(tag, rdata_b, 64'd0);
    end
  endtask

  task automatic fill(input int base);
    for (int i = 1; i < 32; i++) begin
      wen_a = 2'b01; waddr_a[0] = 5'(i); wdata_a[0] = 32'(base + i);
      wen_b = 1'b1;  waddr_b    = 5'(i); wdata_b    = 32'(base + i);
      tick();
    end
    wen_a = '0;
    wen_b = '0;
  endtask

  initial begin
    int n;
    rst_i = 1'b1; clear_i = 1'b0;
    wen_a = '0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
    wen_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
    raddr_a[0] = 5'd5; raddr_a[1] = 5'd6; raddr_b = raddr_a;
    tick();
    tick();
    chk("rst_busy_a", 64'(busy_a), 64'd1);
    chk("rst_busy_b", 64'(busy_b), 64'd1);
    chk("rst_rd_gated_a", rdata_a, 64'd0);
    chk("rst_rd_gated_b", rdata_b, 64'd0);
    rst_i = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin tick(); n++; end
    chk("rst_busy_len", 64'(n), 64'd32);
    chk("rst_busy_b_done", 64'(busy_b), 64'd0);
    rd_all_zero("rst_clear_zero");

    // Entry 0: hard-wired on A (even against bypass), ordinary on B.
    raddr_a[0] = 5'd0; raddr_a[1] = 5'd5; raddr_b = raddr_a;
    wen_a = 2'b01; waddr_a[0] = 5'd0; wdata_a[0] = 32'hDEADBEEF;
    wen_b = 1'b1;  waddr_b    = 5'd0; wdata_b    = 32'hDEADBEEF;
    #1;
    chk("zero_vs_bypass", 64'(rdata_a[0]), 64'd0);
    tick();
    waddr_a[0] = 5'd5; wdata_a[0] = 32'h12345678;
    waddr_b    = 5'd5; wdata_b    = 32'h12345678;
    #1;
    chk("b_addr0_written", 64'(rdata_b[0]), 64'hDEADBEEF);
    chk("b_no_bypass", 64'(rdata_b[1]), 64'd0);
    chk("a_bypass_5", 64'(rdata_a[1]), 64'h12345678);
    tick();
    wen_a = '0; wen_b = '0;
    #1;
    chk("a_addr0_zero", 64'(rdata_a[0]), 64'd0);
    chk("a_rd5", 64'(rdata_a[1]), 64'h12345678);
    chk("b_rd5", 64'(rdata_b[1]), 64'h12345678);

    // Two ports, same address: port 1 wins both in bypass and in storage.
    wen_a = 2'b11;
    waddr_a[0] = 5'd7; wdata_a[0] = 32'hAAAA0000;
    waddr_a[1] = 5'd7; wdata_a[1] = 32'h5555FFFF;
    raddr_a[0] = 5'd7; raddr_a[1] = 5'd8;
    #1;
    chk("bypass_hi_port", 64'(rdata_a[0]), 64'h5555FFFF);
    chk("bypass_miss", 64'(rdata_a[1]), 64'd0);
    tick();
    wen_a = '0;
    #1;
    chk("dual_same_addr", 64'(rdata_a[0]), 64'h5555FFFF);
    wen_a = 2'b11;
    waddr_a[0] = 5'd8;  wdata_a[0] = 32'h11111111;
    waddr_a[1] = 5'd10; wdata_a[1] = 32'h22222222;
    tick();
    wen_a = '0;
    raddr_a[0] = 5'd8; raddr_a[1] = 5'd10;
    #1;
    chk("dual_diff_addr", rdata_a, {32'h22222222, 32'h11111111});

    // Same-cycle write/read of addr 9: forwarded on A, old value on B.
    wen_a = 2'b01; waddr_a[0] = 5'd9; wdata_a[0] = 32'hCAFEF00D;
    wen_b = 1'b1;  waddr_b    = 5'd9; wdata_b    = 32'hCAFEF00D;
    raddr_a[0] = 5'd9; raddr_a[1] = 5'd9; raddr_b = raddr_a;
    #1;
    chk("bypass_a", rdata_a, {32'hCAFEF00D, 32'hCAFEF00D});
    chk("nobypass_b", rdata_b, 64'd0);
    tick();
    wen_a = '0; wen_b = '0;
    #1;
    chk("after_write_a", 64'(rdata_a[0]), 64'hCAFEF00D);
    chk("after_write_b", 64'(rdata_b[0]), 64'hCAFEF00D);

    // Fill, then clear while hammering addr 3 every busy cycle.
    fill(0);
    raddr_a[0] = 5'd3; raddr_a[1] = 5'd31; raddr_b = raddr_a;
    #1;
    chk("fill_a", rdata_a, {32'd31, 32'd3});
    chk("fill_b", rdata_b, {32'd31, 32'd3});
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_busy", 64'(busy_a), 64'd1);
    chk("clr_rd_gated", rdata_a, 64'd0);
    n = 0;
    while (busy_a && n < 100) begin
      wen_a = 2'b01; waddr_a[0] = 5'd3; wdata_a[0] = 32'h333;
      wen_b = 1'b1;  waddr_b    = 5'd3; wdata_b    = 32'h333;
      tick();
      n++;
    end
    wen_a = '0; wen_b = '0;
    chk("clr_len", 64'(n), 64'd32);
    rd_all_zero("clr_zero");

    // Reset at clear cycle 10 restarts; a clear_i pulse while busy is ignored.
    fill(100);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (10) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_mid_busy", 64'(busy_a), 64'd1);
    n = 0;
    while (busy_a && n < 100) begin
      clear_i = (n == 5);
      tick();
      n++;
    end
    clear_i = 1'b0;
    chk("rst_mid_len", 64'(n), 64'd32);
    chk("rst_mid_b_done", 64'(busy_b), 64'd0);
    rd_all_zero("rst_mid_zero");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-cycle 2R/1W integer register file.
- Configurable data width, depth, read-port count and write-port count.
- Optional hard-wired zero entry and optional write-to-read bypass for pipelined cores.
- Clearing is done by an internal sequential-clear state machine (one entry per cycle), not a single-cycle flush, so large depths map to RAM-style storage.

Parameters:
- DATA_W, 32, width of each entry in bits.
- DEPTH, 32, number of entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary entry.
- BYPASS, 0, 1 = a same-cycle write to a read address is forwarded to rd_data_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset; starts a full clear.
- clear_i  in  1  synchronous request to start a full clear; ignored while busy_o=1.
- busy_o  out  1  high while the clear FSM is running.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*ADDR_W  packed write addresses; port k at bits [k*ADDR_W +: ADDR_W].
- wr_data_i  in  NUM_WR*DATA_W  packed write data.
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses.
- rd_data_o  out  NUM_RD*DATA_W  packed read data; combinational.

Behaviour:
- Reset is synchronous and active-high: rst_i=1 at a clock edge sets state=CLEAR, clr_ptr=0, busy_o=1. Reset has priority over clear_i and over all writes.
- FSM states:
  - IDLE -> CLEAR when clear_i=1 or rst_i=1.
  - CLEAR: writes entry[clr_ptr]=0 each cycle and increments clr_ptr. Exits CLEAR -> IDLE on the edge where clr_ptr==DEPTH-1, so the clear takes exactly DEPTH cycles.
  - rst_i asserted mid-CLEAR restarts the pointer at 0.
- busy_o is 1 in CLEAR and 0 in IDLE. After reset is released it stays 1 for DEPTH cycles; busy_o's reset value is 1.
- While busy_o=1: every wr_en_i is ignored (dropped, not queued) and every rd_data_o reads 0.
- Write (IDLE only): on the clock edge, entry[wr_addr_k] <= wr_data_k for each k with wr_en_i[k]=1.
  - If ZERO_REG=1, writes to address 0 are dropped.
  - If both ports target the same address in one cycle, the higher-numbered port wins.
- Read: rd_data_o[j] = entry[rd_addr_j] with zero-cycle combinational latency. A write becomes visible the cycle after its edge.
  - If ZERO_REG=1 and rd_addr_j==0, the port reads 0 regardless of BYPASS.
  - If BYPASS=1, busy_o=0, and some enabled write port matches rd_addr_j, rd_data_o[j] is that port's wr_data (highest-numbered matching port).
- Widths: addresses are exactly ADDR_W bits, so out-of-range access is impossible. Data is never truncated or extended.
- No X propagation: after the clear completes, every entry is defined.

Decomposition:
- Package regfile_pkg:
  - clear-FSM state enum (IDLE, CLEAR);
  - localparam defaults for DATA_W, DEPTH, NUM_RD, NUM_WR;
  - a function that unpacks packed address/data slices.
- One sub-module, regfile_clr_fsm, owns the state, clr_ptr and busy_o, and outputs clr_we and clr_addr. The storage array, write arbitration and read/bypass muxes stay in regfile_mp.

Test Plan:
- Reset release, DEPTH=32: busy_o=1 for exactly 32 cycles, then 0. All 32 entries read 0 through every read port.
- ZERO_REG=1: write 0xDEADBEEF to addr 0, then read addr 0 -> 0. Write 0x12345678 to addr 5, read addr 5 on the next cycle -> 0x12345678.
- NUM_WR=2, same-cycle writes to addr 7 (port0=0xAAAA0000, port1=0x5555FFFF) -> addr 7 reads 0x5555FFFF.
- BYPASS=1: write 0xCAFEF00D to addr 9 while reading addr 9 in the same cycle -> rd_data_o=0xCAFEF00D that cycle. With BYPASS=0 it returns the old value (0).
- Fill entries 1..31 with their index, pulse clear_i, and assert a write to addr 3 during clear -> the write is dropped. After 32 cycles all entries read 0.
- rst_i pulsed at clear cycle 10: busy_o stays high for a further 32 cycles from the reset edge. A clear_i pulse while busy has no extra effect.
